// File: rtl/reset_seq.sv
`default_nettype none
// ============================================================================
// reset_seq: ordered release of N_OUT active-low resets with button debounce,
// lock-loss re-entry and cause report; RESET_SEQ_WDOG_EN adds a RUN watchdog.
// Revision 1.0
// ============================================================================
module reset_seq #(
  parameter int N_OUT           = 2,
  parameter int HOLD_CYCLES     = 255,
  parameter int STAGE_GAP       = 16,
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int SYNC_STAGES     = 2
`ifdef RESET_SEQ_WDOG_EN
  ,
  parameter int WDOG_CYCLES     = 1 << 24
`endif
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             PLL_LOCKED,
  input  logic             BTN,
`ifdef RESET_SEQ_WDOG_EN
  input  logic             KICK,
  output logic [3:0]       CAUSE,
`else
  output logic [2:0]       CAUSE,
`endif
  output logic [N_OUT-1:0] RSTn_O,
  output logic             DONE,
  output logic [7:0]       RST_COUNT
);

  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int GW = (STAGE_GAP > 1) ? $clog2(STAGE_GAP) : 1;
  localparam int DW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int KW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
`ifdef RESET_SEQ_WDOG_EN
  localparam int CW = 4;
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
`else
  localparam int CW = 3;
`endif

  typedef enum logic [1:0] {S_WAIT, S_HOLD, S_STAGE, S_RUN} state_e;

  logic [SYNC_STAGES-1:0] lock_sync_q, btn_sync_q;
  logic                   lock_s, btn_s;
  logic                   deb_q, deb_d, press_q, press_d;
  logic [DW-1:0]          dcnt_q, dcnt_d;
  state_e                 state_q, state_d;
  logic [HW-1:0]          hold_q, hold_d;
  logic [GW-1:0]          gap_q, gap_d;
  logic [KW-1:0]          k_q, k_d;
  logic [N_OUT-1:0]       rstn_q, rstn_d;
  logic                   done_q, done_d;
  logic [CW-1:0]          cause_q, cause_d, fault_cause;
  logic [7:0]             cnt_q, cnt_d;
  logic                   fault;

  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign btn_s  = btn_sync_q[SYNC_STAGES-1];

  // The counter only advances while the synchronised button disagrees with the accepted level.
  always_comb begin
    deb_d   = deb_q;
    dcnt_d  = '0;
    press_d = 1'b0;
    if (btn_s != deb_q) begin
      if (dcnt_q == DW'(DEBOUNCE_CYCLES - 1)) begin
        deb_d   = btn_s;
        press_d = btn_s;
      end else begin
        dcnt_d = dcnt_q + DW'(1);
      end
    end
  end

`ifdef RESET_SEQ_WDOG_EN
  logic [WW-1:0] wdog_q, wdog_d;
  logic          wdog_hit;
  assign wdog_hit    = (state_q == S_RUN) && (wdog_q == WW'(WDOG_CYCLES - 1));
  assign fault       = ~lock_s | press_q | wdog_hit;
  assign fault_cause = {wdog_hit, press_q, ~lock_s, 1'b0};
  always_comb wdog_d = (state_q == S_RUN && state_d == S_RUN && !KICK) ? wdog_q + WW'(1) : '0;
`else
  assign fault       = ~lock_s | press_q;
  assign fault_cause = {press_q, ~lock_s, 1'b0};
`endif

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    k_d     = k_q;
    rstn_d  = rstn_q;
    done_d  = done_q;
    cause_d = cause_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_WAIT: begin
        rstn_d = '0;
        done_d = 1'b0;
        if (lock_s && !deb_q && !fault) begin
          state_d = S_HOLD;
          hold_d  = HW'(HOLD_CYCLES - 1);
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          rstn_d = N_OUT'(1);
          gap_d  = GW'(STAGE_GAP - 1);
          k_d    = KW'(1);
          if (N_OUT == 1) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            state_d = S_STAGE;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      S_STAGE: begin
        if (gap_q == '0) begin
          // Releases form a thermometer code, so shifting in a one frees the next bit.
          rstn_d = (rstn_q << 1) | N_OUT'(1);
          if (k_q == KW'(N_OUT - 1)) begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end else begin
            k_d   = k_q + KW'(1);
            gap_d = GW'(STAGE_GAP - 1);
          end
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: ;
    endcase
    if (state_q != S_WAIT && fault) begin
      state_d = S_WAIT;
      rstn_d  = '0;
      done_d  = 1'b0;
      cause_d = fault_cause;
      if (cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      lock_sync_q <= '0;
      btn_sync_q  <= '0;
      deb_q       <= 1'b0;
      dcnt_q      <= '0;
      press_q     <= 1'b0;
      state_q     <= S_WAIT;
      hold_q      <= '0;
      gap_q       <= '0;
      k_q         <= '0;
      rstn_q      <= '0;
      done_q      <= 1'b0;
      cause_q     <= CW'(1);
      cnt_q       <= '0;
`ifdef RESET_SEQ_WDOG_EN
      wdog_q      <= '0;
`endif
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], PLL_LOCKED};
      btn_sync_q  <= {btn_sync_q[SYNC_STAGES-2:0], BTN};
      deb_q       <= deb_d;
      dcnt_q      <= dcnt_d;
      press_q     <= press_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      gap_q       <= gap_d;
      k_q         <= k_d;
      rstn_q      <= rstn_d;
      done_q      <= done_d;
      cause_q     <= cause_d;
      cnt_q       <= cnt_d;
`ifdef RESET_SEQ_WDOG_EN
      wdog_q      <= wdog_d;
`endif
    end
  end

  assign RSTn_O    = rstn_q;
  assign DONE      = done_q;
  assign CAUSE     = cause_q;
  assign RST_COUNT = cnt_q;

endmodule
`default_nettype wire
